// File: rtl/seq_rec_pkg.sv
// Shared types and reset-default configuration for the serial sequence recognizer.
package seq_rec_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HUNT = 1'b1
    } state_t;

    localparam logic [5:0]  DEF_PATTERN = 6'b101101;
    localparam int unsigned DEF_LEN     = 6;
    localparam logic        DEF_OVL     = 1'b1;

endpackage

// File: rtl/seq_rec_cmp.sv
// Masked equality of the shift history against the pattern over the low len bits.
module seq_rec_cmp #(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               eq
);

    always_comb begin
        eq = 1'b1;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((i < 32'(len)) && (hist[i] != pat[i])) eq = 1'b0;
        end
    end

endmodule

// File: rtl/seq_recognizer_param.sv
// Runtime-programmable serial pattern recognizer with overlap control,
// input qualification and a saturating match counter.
module seq_recognizer_param
    import seq_rec_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               x_valid,
    input  logic               x,
    output logic               y,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    state_t             state_q, state_d;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W:0]     fill_inc;
    logic               accept;
    logic               cfg_bad;
    logic               enough;
    logic               eq;
    logic               hit;

    assign accept   = x_valid && !cfg_load;
    assign cfg_bad  = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
    assign hist_nxt = {hist[MAX_LEN-2:0], x};
    assign fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
    assign enough   = (fill_inc >= {1'b0, len});
    assign hit      = accept && eq && enough;

    seq_rec_cmp #(.MAX_LEN(MAX_LEN)) u_cmp (
        .hist (hist_nxt),
        .pat  (pat),
        .len  (len),
        .eq   (eq)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (cfg_load) begin
                    if (!cfg_bad) state_d = FILL;
                end else if (accept && enough) begin
                    state_d = (hit && !ovl) ? FILL : HUNT;
                end
            end
            HUNT: begin
                if ((cfg_load && !cfg_bad) || (hit && !ovl)) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat         <= MAX_LEN'(DEF_PATTERN);
            len         <= LEN_W'(DEF_LEN);
            ovl         <= DEF_OVL;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            y           <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            y       <= hit;
            cfg_err <= cfg_load && cfg_bad;
            if (cfg_load) begin
                // An illegal length leaves everything untouched; the x bit is dropped either way.
                if (!cfg_bad) begin
                    pat         <= cfg_pattern;
                    len         <= cfg_len;
                    ovl         <= cfg_overlap;
                    hist        <= '0;
                    fill        <= '0;
                    match_count <= '0;
                end
            end else if (x_valid) begin
                hist <= hist_nxt;
                if (hit && !ovl)           fill <= '0;
                else if (fill != MAX_LEN_L) fill <= fill + LEN_W'(1);
                if (hit && (match_count != '1)) match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_recognizer_param.sv
// Directed self-checking bench for seq_recognizer_param (default and 2-bit counter instances).
module tb_seq_recognizer_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       x_valid = 1'b0;
    logic       x = 1'b0;

    logic       y, cfg_err;
    logic [7:0] match_count;
    logic       y2, cfg_err2;
    logic [1:0] match_count2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_recognizer_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .x_valid(x_valid), .x(x), .y(y), .match_count(match_count)
    );

    seq_recognizer_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
        .x_valid(x_valid), .x(x), .y(y2), .match_count(match_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b);
        @(negedge clk);
        cfg_load = 1'b0;
        x_valid  = v;
        x        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_load = 1'b0; x_valid = 1'b0; x = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // x is driven high alongside the load; it must be discarded.
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        x_valid = 1'b1; x = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // seq[n-1] is sent first; exp_y[i] is the required y after bit seq[i].
    task automatic stream(input string tag, input logic [15:0] seq,
                          input logic [15:0] exp_y, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, seq[i]);
            check(tag, {31'd0, y}, {31'd0, exp_y[i]});
        end
    endtask

    initial begin
        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_y", {31'd0, y}, 32'd0);
        check("rst_err", {31'd0, cfg_err}, 32'd0);
        check("rst_cnt", {24'd0, match_count}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Default pattern, single match
        stream("def6_y", 16'b101101, 16'b000001, 6);
        check("def6_cnt", {24'd0, match_count}, 32'd1);
        drive(1'b0, 1'b0);
        check("def6_ylow", {31'd0, y}, 32'd0);

        // Overlap
        do_reset();
        stream("ovl9_y", 16'b101101101, 16'b000001001, 9);
        check("ovl9_cnt", {24'd0, match_count}, 32'd2);

        // Non-overlap reload clears the counter
        load(8'b00101101, 4'd6, 1'b0);
        check("nov_err", {31'd0, cfg_err}, 32'd0);
        check("nov_cnt0", {24'd0, match_count}, 32'd0);
        stream("nov12_y", 16'b101101101101, 16'b000001000001, 12);
        check("nov12_cnt", {24'd0, match_count}, 32'd2);

        // Short pattern with x_valid gaps
        load(8'b00000011, 4'd3, 1'b1);
        drive(1'b1, 1'b0); check("gap_y0", {31'd0, y}, 32'd0);
        drive(1'b0, 1'b1); check("gap_g0", {31'd0, y}, 32'd0);
        drive(1'b1, 1'b1); check("gap_y1", {31'd0, y}, 32'd0);
        drive(1'b0, 1'b0); check("gap_g1", {31'd0, y}, 32'd0);
        drive(1'b1, 1'b1); check("gap_y2", {31'd0, y}, 32'd1);
        drive(1'b0, 1'b1); check("gap_g2", {31'd0, y}, 32'd0);
        check("gap_cnt", {24'd0, match_count}, 32'd1);

        // Illegal lengths keep the default configuration
        do_reset();
        load(8'hFF, 4'd0, 1'b0);
        check("bad0_err", {31'd0, cfg_err}, 32'd1);
        check("bad0_y", {31'd0, y}, 32'd0);
        load(8'hFF, 4'd9, 1'b0);
        check("bad9_err", {31'd0, cfg_err}, 32'd1);
        drive(1'b0, 1'b0);
        check("bad_errlow", {31'd0, cfg_err}, 32'd0);
        stream("bad_def_y", 16'b101101101, 16'b000001001, 9);
        check("bad_def_cnt", {24'd0, match_count}, 32'd2);

        // Saturation on the 2-bit counter, back-to-back overlap matches
        load(8'b00000001, 4'd1, 1'b1);
        check("sat_err", {31'd0, cfg_err2}, 32'd0);
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 1'b1);
            check("sat_y2", {31'd0, y2}, 32'd1);
            check("sat_cnt2", {30'd0, match_count2}, (k < 3) ? k : 32'd3);
        end
        check("sat_cnt8", {24'd0, match_count}, 32'd7);

        // Reset mid-stream discards history
        do_reset();
        stream("mid5_y", 16'b10110, 16'b00000, 5);
        @(negedge clk); rst = 1'b1; x_valid = 1'b1; x = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_y", {31'd0, y}, 32'd0);
        drive(1'b1, 1'b1);
        check("mid6_y", {31'd0, y}, 32'd0);
        check("mid_cnt", {24'd0, match_count}, 32'd0);

        // Reset clears a pending y and the counter
        do_reset();
        stream("pend_y", 16'b101101, 16'b000001, 6);
        @(negedge clk); rst = 1'b1; x_valid = 1'b0;
        @(posedge clk); #1;
        check("pend_rst_y", {31'd0, y}, 32'd0);
        check("pend_rst_cnt", {24'd0, match_count}, 32'd0);
        @(negedge clk); rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_recognizer_param.md
# seq_recognizer_param

Parametrised serial bit-sequence recognizer with a runtime-programmable pattern (1..MAX_LEN bits), selectable overlapping or non-overlapping detection, input qualification and a saturating match counter. It sits on a serial bit stream between a deserialiser/sampler and control logic, and generalises the fixed 101101 recognizer. Reset configuration reproduces pattern 101101 with overlap detection.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits; must be ≥ 6.
- CNT_W, default 8: width of the match counter.
- LEN_W, derived, $clog2(MAX_LEN+1): width of length fields.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_load  in  1  capture cfg_pattern, cfg_len and cfg_overlap this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first-received bit and bit 0 the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse when cfg_load carries an illegal cfg_len.
- x_valid  in  1  x is sampled only when high.
- x  in  1  serial data bit.
- y  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  number of matches, saturating at all-ones.

## Operation
- Registers:
  - pat, len, ovl: active configuration.
  - hist[MAX_LEN-1:0]: shift history; the newest bit is at the LSB.
  - fill[LEN_W-1:0]: number of valid bits since the last clear, saturating at MAX_LEN.
  - FSM state.
- FSM states:
  - FILL: fill < len; no match is possible.
  - HUNT: fill ≥ len.
  - Transitions: FILL→HUNT when an accepted bit makes fill+1 ≥ len. HUNT→FILL on a non-overlap match or a legal cfg_load. rst → FILL.
- Accepted bit (x_valid=1, cfg_load=0):
  - hist ← {hist[MAX_LEN-2:0], x}.
  - fill ← min(fill+1, MAX_LEN).
- Match condition: an accepted bit where the new hist[len-1:0] equals pat[len-1:0] and fill+1 ≥ len. Bits above len-1 are masked.
- On a match:
  - y=1 on the next cycle.
  - match_count increments unless already all-ones.
  - If ovl=0, fill ← 0 and state ← FILL, so the next match needs len fresh bits.
  - If ovl=1, fill and hist are kept, so overlapping matches are reported.
- cfg_load with legal cfg_len:
  - Configuration is replaced.
  - hist, fill and match_count clear to 0; state ← FILL.
  - The x bit in the same cycle is discarded.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN:
  - Configuration and datapath are unchanged.
  - cfg_err=1 on the next cycle.
  - The x bit in the same cycle is still discarded.
- x_valid=0: all state holds and y=0 on the next cycle.

## Timing
- Reset values:
  - y=0, cfg_err=0, match_count=0, hist=0, fill=0, state=FILL.
  - pat = 101101 zero-extended, len=6, ovl=1.
- Latency: the final pattern bit is accepted at edge N; y is high during cycle N+1 and low at N+2 unless another match occurs.
- Back-to-back matches are possible in overlap mode (e.g. pattern 1, len 1, with a stream of 1s gives y high every valid cycle).
- rst takes precedence over cfg_load and x_valid.
- cfg_load takes precedence over x_valid.
- rst mid-stream discards partial history, and a pending y is cleared on the next cycle.
- match_count updates on the same edge as y rises. At all-ones, y still pulses and the count holds.

## Structure
- Package seq_rec_pkg:
  - state enum {FILL, HUNT}.
  - Default constants: DEF_PATTERN = 6'b101101, DEF_LEN = 6, DEF_OVL = 1.
- Sub-module seq_rec_cmp: combinational masked compare of hist against pat over len bits, parametrised by MAX_LEN.
- Top module holds the configuration registers, shifter, fill counter, FSM, counter and output registers.

## Test plan
- Reset defaults, stream 1,0,1,1,0,1 (x_valid=1) → y pulses once, one cycle after the 6th bit; match_count=1.
- Defaults, stream 101101101 → matches after bits 6 and 9; match_count=2.
- cfg_load pattern 101101, len 6, cfg_overlap=0, stream 101101101101 → matches only after bits 6 and 12; match_count=2.
- cfg_load pattern 0b011, len 3, overlap; stream 0,1,1 with x_valid=0 gaps between bits → one match, y one cycle after the last valid bit.
- cfg_load with cfg_len=0 → cfg_err pulses; default pattern is still detected.
- CNT_W=2, pattern 1, len 1, seven 1s → y pulses 7 times; match_count stops at 3.
- Assert rst after 5 bits of 101101, then send the 6th bit → no y.
